// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that shares one UART byte stream between NUM_REQ sources,
// wrapping each granted payload as SOF, id, len, payload, XOR checksum.
module uart_frame_arbiter #(
  parameter int         NUM_REQ = 4,
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = 8'hA5
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0][7:0] req_len,
  input  logic [NUM_REQ-1:0][7:0] pl_data,
  output logic [NUM_REQ-1:0]      pl_rd,
  output logic [NUM_REQ-1:0]      grant,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err_len
);
  localparam int         IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] MAXL8 = 8'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_SOF, S_ID, S_LEN, S_PAY, S_CSUM} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, sel_q, sel_d, arb_idx;
  logic [7:0]         len_q, len_d, cnt_q, cnt_d, csum_q, csum_d, txd_q, txd_d;
  logic               txv_q, txv_d, fd_q, fd_d, el_q, el_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               arb_hit, len_ok, beat, more;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  // First requester at or after ptr, walking modulo NUM_REQ.
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    arb_hit = 1'b0;
    arb_idx = '0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IW'(j);
      if (!arb_hit && req[jj]) begin
        arb_hit = 1'b1;
        arb_idx = jj;
      end
    end
  end

  assign len_ok = (req_len[arb_idx] <= MAXL8);
  assign beat   = txv_q & tx_ready;
  assign more   = (cnt_q < len_q);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      gnt_q   <= '0;
      fd_q    <= 1'b0;
      el_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      gnt_q   <= gnt_d;
      fd_q    <= fd_d;
      el_q    <= el_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arb_hit && len_ok) state_d = S_SOF;
      S_SOF:   if (beat) state_d = S_ID;
      S_ID:    if (beat) state_d = S_LEN;
      S_LEN:   if (beat) state_d = (len_q == 8'd0) ? S_CSUM : S_PAY;
      S_PAY:   if (beat && !more) state_d = S_CSUM;
      S_CSUM:  if (beat) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: the next byte is loaded on the same edge that retires the current one.
  always_comb begin
    ptr_d  = ptr_q;
    sel_d  = sel_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    csum_d = csum_q;
    txd_d  = txd_q;
    txv_d  = txv_q;
    gnt_d  = gnt_q;
    fd_d   = 1'b0;
    el_d   = 1'b0;
    case (state_q)
      S_IDLE: if (arb_hit) begin
        if (!len_ok) begin
          el_d  = 1'b1;
          ptr_d = inc_wrap(arb_idx);
        end else begin
          sel_d  = arb_idx;
          len_d  = req_len[arb_idx];
          csum_d = '0;
          txd_d  = SOF;
          txv_d  = 1'b1;
          gnt_d  = NUM_REQ'(1) << arb_idx;
        end
      end
      S_SOF: if (beat) txd_d = {{(8-IW){1'b0}}, sel_q};
      S_ID: if (beat) begin
        txd_d  = len_q;
        csum_d = csum_q ^ txd_q;
      end
      S_LEN: if (beat) begin
        csum_d = csum_q ^ len_q;
        if (len_q == 8'd0) txd_d = csum_q ^ len_q;
        else begin
          txd_d = pl_data[sel_q];
          cnt_d = 8'd1;
        end
      end
      S_PAY: if (beat) begin
        csum_d = csum_q ^ txd_q;
        if (more) begin
          txd_d = pl_data[sel_q];
          cnt_d = cnt_q + 8'd1;
        end else txd_d = csum_q ^ txd_q;
      end
      S_CSUM: if (beat) begin
        txv_d = 1'b0;
        gnt_d = '0;
        fd_d  = 1'b1;
        ptr_d = inc_wrap(sel_q);
      end
      default: ;
    endcase
  end

  // Pop strobe only on the beats that load a payload byte.
  always_comb begin
    pl_rd = '0;
    if (beat && ((state_q == S_LEN && len_q != 8'd0) || (state_q == S_PAY && more)))
      pl_rd[sel_q] = 1'b1;
    busy = (state_q != S_IDLE);
  end

  assign tx_data    = txd_q;
  assign tx_valid   = txv_q;
  assign grant      = gnt_q;
  assign frame_done = fd_q;
  assign err_len    = el_q;

  a_grant_onehot: assert property (@(posedge clk_in) disable iff (rst) $onehot0(grant));
  a_rd_granted:   assert property (@(posedge clk_in) disable iff (rst) (pl_rd & ~grant) == '0);
endmodule

// File: doc/uart_frame_arbiter.md
# uart_frame_arbiter

Round-robin arbiter that shares one UART transmit path between NUM_REQ byte-stream requesters. It grants one requester at a time and wraps that requester's payload in a frame: SOF, source ID, length, payload, XOR checksum. It emits the frame one byte at a time on a valid/ready handshake. It sits between the per-source FIFOs and the packetizer/transmitter input.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8
- MAX_LEN, 16, largest legal payload length in bytes; legal range 1..255
- SOF, 8'hA5, start-of-frame byte
- clk_in  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  bit i high: requester i has a complete frame ready
- req_len  in  8*NUM_REQ  payload length of requester i in bits [8i+7:8i]; 0 is legal
- pl_data  in  8*NUM_REQ  show-ahead payload byte of requester i
- pl_rd  out  NUM_REQ  one-cycle pop strobe to the granted requester; combinational
- grant  out  NUM_REQ  one-hot grant, held for the whole frame
- tx_data  out  8  frame byte; registered
- tx_valid  out  1  tx_data valid; registered
- tx_ready  in  1  downstream accepts the byte
- busy  out  1  high whenever the state is not IDLE
- frame_done  out  1  one-cycle pulse after the checksum byte is accepted
- err_len  out  1  one-cycle pulse when a request is rejected for length

## Operation
- A beat is a cycle with tx_valid && tx_ready.
- While tx_valid is high and tx_ready is low, tx_data is held stable.
- A new byte loads into the output register on the same edge as the beat that retires the previous byte, so beats can be back-to-back.
- States and transitions:
  - IDLE: tx_valid=0, grant=0.
    - If any req bit is high, select the first set bit at or after pointer ptr, in modulo-NUM_REQ order.
    - If the selected len > MAX_LEN: pulse err_len, set ptr = sel+1, stay in IDLE.
    - Otherwise: set grant[sel], latch id = sel and len, clear csum, load tx_data=SOF, tx_valid=1, go to SOF.
  - SOF: on beat, load id (zero-extended to 8 bits); go to ID.
  - ID: on beat, load len; csum ^= id; go to LEN.
  - LEN: on beat, csum ^= len.
    - If len==0: load csum; go to CSUM.
    - Otherwise: load pl_data[sel] with pl_rd[sel]=1 this cycle; set cnt=1; go to PAYLOAD.
  - PAYLOAD: on beat, csum ^= the accepted byte.
    - If cnt<len: load the next pl_data byte, pulse pl_rd, cnt++.
    - Otherwise: load the final csum, which includes the last byte; go to CSUM.
  - CSUM: on beat, tx_valid=0, grant=0, frame_done=1, ptr = sel+1 mod NUM_REQ; go to IDLE.
- Checksum is the XOR of the ID byte, the length byte and all payload bytes. SOF is excluded.
- pl_rd asserts exactly once per payload byte, never during a stall, and only on the granted requester's bit.
- req and req_len are sampled only in IDLE. Deasserting req mid-frame has no effect; the frame completes. The requester must keep pl_data valid until the frame ends.
- ptr wraps from NUM_REQ-1 to 0.
- Reset (async, at any time, including mid-frame):
  - state=IDLE, ptr=0, cnt=0, csum=0.
  - Outputs: tx_valid=0, tx_data=0, grant=0, busy=0, frame_done=0, err_len=0, pl_rd=0.
  - A partial frame is dropped; no checksum byte is sent.

## Timing
- A req seen high in IDLE at edge k gives grant and tx_valid (SOF) visible after edge k.
- With tx_ready held high, a frame of L payload bytes occupies L+4 consecutive beats.
- frame_done is high the cycle after the checksum beat, together with IDLE.
- The next frame's SOF appears at the earliest one cycle after frame_done. The gap between frames is therefore at least 1 idle cycle.
- A length rejection costs 1 IDLE cycle. Arbitration then reevaluates from the new ptr on the next cycle.
- Latency from a beat to the next byte's tx_valid is 0 cycles. Each stall cycle adds exactly 1 cycle.

## Test plan
- Single request, tx_ready=1: req[1]=1, len=2, payload 8'h11 then 8'h22.
  - Required stream: A5 01 02 11 22 30.
  - pl_rd[1] pulses exactly twice.
  - frame_done pulses once.
- Round robin: all four req high, every len=0.
  - Grant order is 0,1,2,3,0.
  - Each frame is A5, id, 00, id.
  - There is at least 1 idle cycle between frames.
- Backpressure: len=3, tx_ready toggled pseudo-randomly.
  - tx_data stays stable while stalled.
  - Byte sequence and checksum match the unstalled run.
  - pl_rd count is 3.
- Length error, MAX_LEN=16:
  - req[2] with len=20: err_len pulses for 1 cycle, no tx_valid, grant stays 0.
  - With req[3] also high, req[3] is granted next.
- Boundary length: len=16 with payload 00..0F.
  - 20 beats.
  - Checksum = id ^ 8'h10 ^ (XOR of 00..0F) = id ^ 8'h10.
- Reset mid-payload: assert rst during byte 2 of a 5-byte frame.
  - All outputs go to 0 immediately.
  - After release, a new request starts with A5 and ptr=0 priority.
